// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter (icache/dcache) onto a single memory bus, one transaction in flight.
// Grant registers the request in IDLE; completion passes m_rdata/m_busy straight back to the owner.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  // icache side
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_ren,
  input  logic                    i_wen,
  input  logic [DATA_WIDTH/8-1:0] i_byte_en,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_busy,
  // dcache side
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic                    d_ren,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH/8-1:0] d_byte_en,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_busy,
  // downstream memory
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic                    m_ren,
  output logic                    m_wen,
  output logic [DATA_WIDTH/8-1:0] m_byte_en,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_d_q, last_d_d;   // 1: dcache was granted most recently
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] be_q, be_d;
  logic                    ren_q, ren_d;
  logic                    wen_q, wen_d;

  logic i_req, d_req;
  logic grant_i, grant_d;
  logic i_done, d_done;

  assign i_req = i_ren | i_wen;
  assign d_req = d_ren | d_wen;

  // Tie goes to whoever did not win last; a single requester always wins.
  assign grant_d = (state_q == IDLE) && d_req && (!i_req || !last_d_q);
  assign grant_i = (state_q == IDLE) && i_req && !grant_d;

  // Completion is suppressed while reset is held so an abandoned transfer never reports done.
  assign i_done = (state_q == GRANT_I) && !m_busy && !RST;
  assign d_done = (state_q == GRANT_D) && !m_busy && !RST;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d  = GRANT_D;
          last_d_d = 1'b1;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          be_d     = d_byte_en;
          ren_d    = d_ren & ~d_wen;
          wen_d    = d_wen;
        end else if (grant_i) begin
          state_d  = GRANT_I;
          last_d_d = 1'b0;
          addr_d   = i_addr;
          wdata_d  = i_wdata;
          be_d     = i_byte_en;
          ren_d    = i_ren & ~i_wen;
          wen_d    = i_wen;
        end
      end
      GRANT_I: if (!m_busy) state_d = IDLE;
      GRANT_D: if (!m_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
    end
  end

  always_comb begin
    m_addr    = addr_q;
    m_wdata   = wdata_q;
    m_byte_en = be_q;
    m_ren     = 1'b0;
    m_wen     = 1'b0;
    i_busy    = 1'b1;
    d_busy    = 1'b1;
    i_rdata   = '0;
    d_rdata   = '0;
    if (state_q != IDLE) begin
      m_ren = ren_q;
      m_wen = wen_q;
    end
    if (i_done) begin
      i_busy  = 1'b0;
      i_rdata = m_rdata;
    end
    if (d_done) begin
      d_busy  = 1'b0;
      d_rdata = m_rdata;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, single read, tie-break, alternation, write priority, reset abort.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
  logic        i_ren, i_wen, d_ren, d_wen, m_busy;
  logic [3:0]  i_byte_en, d_byte_en;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_busy, d_busy, m_ren, m_wen;
  logic [3:0]  m_byte_en;

  int n_cmp  = 0;
  int n_fail = 0;

  memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_ren(i_ren), .i_wen(i_wen), .i_byte_en(i_byte_en),
    .i_rdata(i_rdata), .i_busy(i_busy),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ren(d_ren), .d_wen(d_wen), .d_byte_en(d_byte_en),
    .d_rdata(d_rdata), .d_busy(d_busy),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ren(m_ren), .m_wen(m_wen), .m_byte_en(m_byte_en),
    .m_rdata(m_rdata), .m_busy(m_busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set afterwards apply to that cycle.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST = 1'b1;
    i_addr = '0; i_wdata = '0; i_ren = 0; i_wen = 0; i_byte_en = '0;
    d_addr = '0; d_wdata = '0; d_ren = 0; d_wen = 0; d_byte_en = '0;
    m_rdata = 32'hDEADBEEF; m_busy = 1'b1;
    cyc(); cyc();
    settle();
    chk("rst_m_ren", {31'd0, m_ren}, 0);
    chk("rst_m_wen", {31'd0, m_wen}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_be", {28'd0, m_byte_en}, 0);
    chk("rst_i_busy", {31'd0, i_busy}, 1);
    chk("rst_d_busy", {31'd0, d_busy}, 1);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // Single icache read at 0x100, memory busy three cycles.
    RST = 1'b0;
    cyc();
    i_ren = 1; i_addr = 32'h100; m_busy = 1;
    settle();
    chk("rd_idle_m_ren", {31'd0, m_ren}, 0);
    chk("rd_idle_i_busy", {31'd0, i_busy}, 1);
    cyc();
    i_ren = 0;   // requester drops after grant; transfer must still finish
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rd_wait_m_ren", {31'd0, m_ren}, 1);
      chk("rd_wait_m_addr", m_addr, 32'h100);
      chk("rd_wait_i_busy", {31'd0, i_busy}, 1);
      chk("rd_wait_i_rdata", i_rdata, 0);
      chk("rd_wait_d_busy", {31'd0, d_busy}, 1);
      cyc();
    end
    m_busy = 0;
    settle();
    chk("rd_done_m_ren", {31'd0, m_ren}, 1);
    chk("rd_done_i_busy", {31'd0, i_busy}, 0);
    chk("rd_done_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("rd_done_d_busy", {31'd0, d_busy}, 1);
    chk("rd_done_d_rdata", d_rdata, 0);
    cyc();
    settle();
    chk("rd_after_m_ren", {31'd0, m_ren}, 0);
    chk("rd_after_i_busy", {31'd0, i_busy}, 1);
    chk("rd_after_m_addr", m_addr, 32'h100);

    // Tie right after reset: dcache write first, then icache read.
    RST = 1;
    cyc();
    RST = 0;
    i_ren = 1; i_addr = 32'h200;
    d_wen = 1; d_addr = 32'h300; d_wdata = 32'h55AA; d_byte_en = 4'hF;
    m_busy = 0;
    settle();
    chk("tie_rst_cycle_m_wen", {31'd0, m_wen}, 0);
    cyc();
    settle();
    chk("tie_d_m_wen", {31'd0, m_wen}, 1);
    chk("tie_d_m_ren", {31'd0, m_ren}, 0);
    chk("tie_d_m_addr", m_addr, 32'h300);
    chk("tie_d_m_wdata", m_wdata, 32'h55AA);
    chk("tie_d_m_be", {28'd0, m_byte_en}, 32'hF);
    chk("tie_d_d_busy", {31'd0, d_busy}, 0);
    chk("tie_d_i_busy", {31'd0, i_busy}, 1);
    d_wen = 0;
    cyc();
    settle();
    chk("tie_gap_m_wen", {31'd0, m_wen}, 0);
    chk("tie_gap_m_ren", {31'd0, m_ren}, 0);
    chk("tie_gap_i_busy", {31'd0, i_busy}, 1);
    cyc();
    settle();
    chk("tie_i_m_ren", {31'd0, m_ren}, 1);
    chk("tie_i_m_addr", m_addr, 32'h200);
    chk("tie_i_i_busy", {31'd0, i_busy}, 0);
    chk("tie_i_d_busy", {31'd0, d_busy}, 1);
    i_ren = 0;
    cyc();

    // Both held with m_busy=0: IDLE,D,IDLE,I,IDLE,D,IDLE,I.
    i_ren = 1; i_addr = 32'hA0;
    d_ren = 1; d_addr = 32'hB0;
    m_busy = 0;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("alt_d_busy", {31'd0, d_busy}, (k % 4 == 1) ? 32'd0 : 32'd1);
      chk("alt_i_busy", {31'd0, i_busy}, (k % 4 == 3) ? 32'd0 : 32'd1);
      chk("alt_m_ren", {31'd0, m_ren}, (k % 2 == 1) ? 32'd1 : 32'd0);
      cyc();
    end
    i_ren = 0; d_ren = 0;
    settle();
    chk("alt_end_m_ren", {31'd0, m_ren}, 0);

    // ren and wen together is a write.
    d_ren = 1; d_wen = 1; d_addr = 32'h40; d_wdata = 32'h1234; d_byte_en = 4'h3;
    cyc();
    d_ren = 0; d_wen = 0;
    settle();
    chk("rw_m_wen", {31'd0, m_wen}, 1);
    chk("rw_m_ren", {31'd0, m_ren}, 0);
    chk("rw_m_be", {28'd0, m_byte_en}, 32'h3);
    chk("rw_d_busy", {31'd0, d_busy}, 0);
    cyc();

    // Reset while icache transfer is pending: abandoned silently.
    i_ren = 1; i_addr = 32'h80; m_busy = 1;
    cyc();
    settle();
    chk("ab_m_ren", {31'd0, m_ren}, 1);
    RST = 1; i_ren = 0; m_busy = 0;
    settle();
    chk("ab_rst_i_busy", {31'd0, i_busy}, 1);
    chk("ab_rst_i_rdata", i_rdata, 0);
    cyc();
    RST = 0;
    settle();
    chk("ab_post_m_ren", {31'd0, m_ren}, 0);
    chk("ab_post_i_busy", {31'd0, i_busy}, 1);
    chk("ab_post_m_addr", m_addr, 0);
    cyc();
    settle();
    chk("ab_idle_m_ren", {31'd0, m_ren}, 0);
    chk("ab_idle_i_busy", {31'd0, i_busy}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
